// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source skid FIFOs for ALU and LSB results,
// one round-robin grant per cycle onto a registered CDB broadcast.
module cdb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [DATA_W-1:0]    alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [DATA_W-1:0]    lsb_result_val,
  output logic                 cdb_valid,
  output logic [ROB_POS_W-1:0] cdb_rob_pos,
  output logic [DATA_W-1:0]    cdb_val,
  output logic                 cdb_src,
  output logic                 alu_stall,
  output logic                 lsb_stall,
  output logic                 ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ROB_POS_W-1:0] r_pos_mem [2][DEPTH];
  logic [DATA_W-1:0]    r_val_mem [2][DEPTH];
  logic [PW-1:0]        r_head [2];
  logic [PW-1:0]        r_tail [2];
  logic [CW-1:0]        r_cnt  [2];
  logic [1:0]           r_stall;
  logic                 r_last_grant;
  logic                 r_cdb_valid;
  logic [ROB_POS_W-1:0] r_cdb_rob_pos;
  logic [DATA_W-1:0]    r_cdb_val;
  logic                 r_cdb_src;
  logic                 r_ovf_err;

  logic [1:0]           w_in_vld, w_has_head, w_cand, w_gnt;
  logic [1:0]           w_push_req, w_push, w_pop, w_drop;
  logic [ROB_POS_W-1:0] w_in_pos   [2];
  logic [DATA_W-1:0]    w_in_val   [2];
  logic [ROB_POS_W-1:0] w_cand_pos [2];
  logic [DATA_W-1:0]    w_cand_val [2];
  logic [CW-1:0]        w_cnt_nxt  [2];
  logic                 w_gnt_src;

  assign w_in_vld    = {lsb_result, alu_result};
  assign w_in_pos[0] = alu_result_rob_pos;
  assign w_in_pos[1] = lsb_result_rob_pos;
  assign w_in_val[0] = alu_result_val;
  assign w_in_val[1] = lsb_result_val;
  assign w_gnt_src   = w_gnt[1];

  always_comb begin
    w_has_head = '0;
    w_cand     = '0;
    w_gnt      = '0;
    w_push_req = '0;
    w_push     = '0;
    w_pop      = '0;
    w_drop     = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      w_has_head[s] = (r_cnt[s] != '0);
      w_cand[s]     = w_has_head[s] | w_in_vld[s];
      w_cand_pos[s] = w_has_head[s] ? r_pos_mem[s][r_head[s]] : w_in_pos[s];
      w_cand_val[s] = w_has_head[s] ? r_val_mem[s][r_head[s]] : w_in_val[s];
    end
    // On a tie the source that did not win last time is served.
    w_gnt[0] = w_cand[0] & (~w_cand[1] | r_last_grant);
    w_gnt[1] = w_cand[1] & ~w_gnt[0];
    for (int unsigned s = 0; s < 2; s++) begin
      w_pop[s]      = w_gnt[s] & w_has_head[s];
      // An incoming result bypasses the FIFO only when it is itself granted.
      w_push_req[s] = w_in_vld[s] & ~(w_gnt[s] & ~w_has_head[s]);
      w_push[s]     = w_push_req[s] & ((r_cnt[s] != CW'(DEPTH)) | w_pop[s]);
      w_drop[s]     = w_push_req[s] & ~w_push[s];
      w_cnt_nxt[s]  = r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (w_push[s]) begin
          r_pos_mem[s][r_tail[s]] <= w_in_pos[s];
          r_val_mem[s][r_tail[s]] <= w_in_val[s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < 2; s++) begin
        r_head[s] <= '0;
        r_tail[s] <= '0;
        r_cnt[s]  <= '0;
      end
      r_stall       <= '0;
      r_last_grant  <= 1'b1;
      r_cdb_valid   <= 1'b0;
      r_cdb_rob_pos <= '0;
      r_cdb_val     <= '0;
      r_cdb_src     <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        for (int unsigned s = 0; s < 2; s++) begin
          r_head[s] <= '0;
          r_tail[s] <= '0;
          r_cnt[s]  <= '0;
        end
        r_stall      <= '0;
        r_last_grant <= 1'b1;
        r_cdb_valid  <= 1'b0;
      end else begin
        r_cdb_valid <= |w_gnt;
        if (|w_gnt) begin
          r_cdb_rob_pos <= w_cand_pos[w_gnt_src];
          r_cdb_val     <= w_cand_val[w_gnt_src];
          r_cdb_src     <= w_gnt_src;
          r_last_grant  <= w_gnt_src;
        end
        for (int unsigned s = 0; s < 2; s++) begin
          if (w_pop[s])  r_head[s] <= r_head[s] + PW'(1);
          if (w_push[s]) r_tail[s] <= r_tail[s] + PW'(1);
          r_cnt[s]   <= w_cnt_nxt[s];
          r_stall[s] <= (w_cnt_nxt[s] >= CW'(DEPTH - 1));
        end
        if (|w_drop) r_ovf_err <= 1'b1;
      end
    end
  end

  assign cdb_valid   = r_cdb_valid;
  assign cdb_rob_pos = r_cdb_rob_pos;
  assign cdb_val     = r_cdb_val;
  assign cdb_src     = r_cdb_src;
  assign alu_stall   = r_stall[0];
  assign lsb_stall   = r_stall[1];
  assign ovf_err     = r_ovf_err;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (DEPTH=4, 4-bit tags, 32-bit data).
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rdy, rollback;
  logic        alu_result, lsb_result;
  logic [3:0]  alu_pos, lsb_pos;
  logic [31:0] alu_val, lsb_val;
  logic        cdb_valid, cdb_src, alu_stall, lsb_stall, ovf_err;
  logic [3:0]  cdb_rob_pos;
  logic [31:0] cdb_val;
  logic [37:0] obs;
  logic [37:0] exp_obs;
  int unsigned passed = 0;
  int unsigned total  = 0;

  cdb_arbiter #(.DEPTH(4), .ROB_POS_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .alu_result(alu_result), .alu_result_rob_pos(alu_pos), .alu_result_val(alu_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_pos), .lsb_result_val(lsb_val),
    .cdb_valid(cdb_valid), .cdb_rob_pos(cdb_rob_pos), .cdb_val(cdb_val), .cdb_src(cdb_src),
    .alu_stall(alu_stall), .lsb_stall(lsb_stall), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;
  assign obs = {cdb_valid, cdb_src, cdb_rob_pos, cdb_val};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alu_result = 1'b0;
    lsb_result = 1'b0;
    rollback   = 1'b0;
  endtask

  task automatic drive(input logic a, input logic [3:0] ap, input logic [31:0] av,
                       input logic l, input logic [3:0] lp, input logic [31:0] lv);
    alu_result = a; alu_pos = ap; alu_val = av;
    lsb_result = l; lsb_pos = lp; lsb_val = lv;
  endtask

  task automatic do_reset();
    clr();
    rdy   = 1'b1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; clr();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #12;
    total++;
    if ({obs, alu_stall, lsb_stall, ovf_err} !== 41'd0)
      $display("FAIL reset_outputs got %h want 0", {obs, alu_stall, lsb_stall, ovf_err});
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0);
    tick(); clr();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd3, 32'h11}) $display("FAIL single_out got %h want %h", obs, {1'b1, 1'b0, 4'd3, 32'h11});
    else passed++;
    tick();
    total++;
    if (cdb_valid !== 1'b0) $display("FAIL single_pulse got %b want 0", cdb_valid);
    else passed++;
  endtask

  task automatic test_tie();
    do_reset();
    drive(1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hB2);
    tick(); clr();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd1, 32'hA1}) $display("FAIL tie_first got %h want %h", obs, {1'b1, 1'b0, 4'd1, 32'hA1});
    else passed++;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 4'd2, 32'hB2}) $display("FAIL tie_second got %h want %h", obs, {1'b1, 1'b1, 4'd2, 32'hB2});
    else passed++;
    tick();
    total++;
    if (cdb_valid !== 1'b0) $display("FAIL tie_empty got %b want 0", cdb_valid);
    else passed++;
  endtask

  // ALU tag k -> pos k+1, val 0x100+k; LSB tag k -> pos k+8, val 0x200+k.
  // LSB holds off in cycle 5 because lsb_stall is high after edge 4.
  task automatic test_back_to_back();
    logic [1:0] exp_st;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c <= 4) drive(1'b1, 4'(c + 1), 32'h100 + c, 1'b1, 4'(c + 8), 32'h200 + c);
      else if (c == 5) drive(1'b1, 4'(c + 1), 32'h100 + c, 1'b0, 4'd0, 32'd0);
      else clr();
      tick();
      if (c == 11) exp_obs = '0;
      else if (c % 2 == 0) exp_obs = {1'b1, 1'b0, 4'(c / 2 + 1), 32'h100 + c / 2};
      else exp_obs = {1'b1, 1'b1, 4'((c - 1) / 2 + 8), 32'h200 + (c - 1) / 2};
      total++;
      if ((c == 11 && cdb_valid !== 1'b0) || (c != 11 && obs !== exp_obs))
        $display("FAIL b2b_cdb[%0d] got %h want %h", c, obs, exp_obs);
      else passed++;
      exp_st = (c == 4) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
      total++;
      if ({alu_stall, lsb_stall} !== exp_st)
        $display("FAIL b2b_stall[%0d] got %b want %b", c, {alu_stall, lsb_stall}, exp_st);
      else passed++;
    end
    total++;
    if (ovf_err !== 1'b0) $display("FAIL b2b_ovf got %b want 0", ovf_err);
    else passed++;
  endtask

  task automatic test_rollback();
    do_reset();
    drive(1'b1, 4'd1, 32'h31, 1'b1, 4'd2, 32'h32); tick();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd1, 32'h31}) $display("FAIL rb_q0 got %h want %h", obs, {1'b1, 1'b0, 4'd1, 32'h31});
    else passed++;
    drive(1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h34); tick();
    total++;
    if (obs !== {1'b1, 1'b1, 4'd2, 32'h32}) $display("FAIL rb_q1 got %h want %h", obs, {1'b1, 1'b1, 4'd2, 32'h32});
    else passed++;
    drive(1'b1, 4'd5, 32'h35, 1'b1, 4'd6, 32'h36); tick();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd3, 32'h33}) $display("FAIL rb_q2 got %h want %h", obs, {1'b1, 1'b0, 4'd3, 32'h33});
    else passed++;
    drive(1'b1, 4'd7, 32'h37, 1'b1, 4'd8, 32'h38); rollback = 1'b1; tick(); clr();
    total++;
    if ({cdb_valid, alu_stall, lsb_stall} !== 3'b000) $display("FAIL rb_flush got %b want 000", {cdb_valid, alu_stall, lsb_stall});
    else passed++;
    tick();
    total++;
    if (cdb_valid !== 1'b0) $display("FAIL rb_empty got %b want 0", cdb_valid);
    else passed++;
    drive(1'b1, 4'd9, 32'h39, 1'b1, 4'd10, 32'h3A); tick(); clr();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd9, 32'h39}) $display("FAIL rb_new_alu got %h want %h", obs, {1'b1, 1'b0, 4'd9, 32'h39});
    else passed++;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 4'd10, 32'h3A}) $display("FAIL rb_new_lsb got %h want %h", obs, {1'b1, 1'b1, 4'd10, 32'h3A});
    else passed++;
    tick();
    total++;
    if (cdb_valid !== 1'b0) $display("FAIL rb_tail got %b want 0", cdb_valid);
    else passed++;
  endtask

  task automatic test_rdy();
    do_reset();
    drive(1'b1, 4'd1, 32'h51, 1'b1, 4'd2, 32'h52); tick();
    drive(1'b1, 4'd3, 32'h53, 1'b1, 4'd4, 32'h54); tick();
    drive(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h56); tick();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd3, 32'h53}) $display("FAIL rdy_pre got %h want %h", obs, {1'b1, 1'b0, 4'd3, 32'h53});
    else passed++;
    rdy = 1'b0;
    drive(1'b1, 4'd7, 32'h57, 1'b1, 4'd8, 32'h58); rollback = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({obs, alu_stall, lsb_stall, ovf_err} !== {1'b1, 1'b0, 4'd3, 32'h53, 3'b000})
        $display("FAIL rdy_hold[%0d] got %h want %h", c, obs, {1'b1, 1'b0, 4'd3, 32'h53});
      else passed++;
    end
    clr(); rdy = 1'b1;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 4'd4, 32'h54}) $display("FAIL rdy_d0 got %h want %h", obs, {1'b1, 1'b1, 4'd4, 32'h54});
    else passed++;
    tick();
    total++;
    if (obs !== {1'b1, 1'b0, 4'd5, 32'h55}) $display("FAIL rdy_d1 got %h want %h", obs, {1'b1, 1'b0, 4'd5, 32'h55});
    else passed++;
    tick();
    total++;
    if (obs !== {1'b1, 1'b1, 4'd6, 32'h56}) $display("FAIL rdy_d2 got %h want %h", obs, {1'b1, 1'b1, 4'd6, 32'h56});
    else passed++;
    tick();
    total++;
    if (cdb_valid !== 1'b0) $display("FAIL rdy_d3 got %b want 0", cdb_valid);
    else passed++;
  endtask

  // Both sources issue every cycle 0..8 ignoring stall; the LSB result of cycle 8
  // (pos 15) arrives on a full FIFO while the ALU holds the grant and is dropped.
  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      if (c <= 8) drive(1'b1, 4'(c), 32'hA00 + c, 1'b1, 4'(c + 7), 32'hB00 + c);
      else clr();
      tick();
      if (c == 17) exp_obs = '0;
      else if (c % 2 == 0) exp_obs = {1'b1, 1'b0, 4'(c / 2), 32'hA00 + c / 2};
      else exp_obs = {1'b1, 1'b1, 4'((c - 1) / 2 + 7), 32'hB00 + (c - 1) / 2};
      total++;
      if ((c == 17 && cdb_valid !== 1'b0) || (c != 17 && obs !== exp_obs))
        $display("FAIL ovf_cdb[%0d] got %h want %h", c, obs, exp_obs);
      else passed++;
      total++;
      if (ovf_err !== (c >= 8)) $display("FAIL ovf_flag[%0d] got %b want %b", c, ovf_err, (c >= 8));
      else passed++;
    end
    rollback = 1'b1; tick(); clr();
    total++;
    if ({cdb_valid, ovf_err} !== 2'b01) $display("FAIL ovf_sticky_rb got %b want 01", {cdb_valid, ovf_err});
    else passed++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0);
    tick(); clr();
    total++;
    if ({obs, ovf_err} !== {1'b1, 1'b0, 4'd5, 32'h55, 1'b1})
      $display("FAIL areset_pre got %h want %h", {obs, ovf_err}, {1'b1, 1'b0, 4'd5, 32'h55, 1'b1});
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({obs, alu_stall, lsb_stall, ovf_err} !== 41'd0)
      $display("FAIL areset_now got %h want 0", {obs, alu_stall, lsb_stall, ovf_err});
    else passed++;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_rollback();
    test_rdy();
    test_overflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
